// File: rtl/lab2_proc_imem_resp_filter.sv
// Fetch-side filter for imem port 0: caps outstanding requests, drops squashed responses and
// queues survivors in a 2-entry FIFO. Define LAB2_PROC_IMEM_FILTER_STATS_EN for a drop counter.
module lab2_proc_imem_resp_filter #(
  parameter int unsigned p_max_inflight = 4,
  parameter int unsigned p_opaque_nbits = 8,
  // Default widths match mem_req_4B_t / mem_resp_4B_t (type, opaque, addr/test, len, data).
  parameter int unsigned c_req_nbits    = 3 + p_opaque_nbits + 32 + 2 + 32,
  parameter int unsigned c_resp_nbits   = 3 + p_opaque_nbits + 2 + 2 + 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    squash,

  input  logic                    proc_req_val,
  output logic                    proc_req_rdy,
  input  logic [c_req_nbits-1:0]  proc_req_msg,

  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic [c_req_nbits-1:0]  mem_req_msg,

  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,
  input  logic [c_resp_nbits-1:0] mem_resp_msg,

  output logic                    proc_resp_val,
  input  logic                    proc_resp_rdy,
  output logic [c_resp_nbits-1:0] proc_resp_msg
`ifdef LAB2_PROC_IMEM_FILTER_STATS_EN
  ,
  output logic [31:0]             num_dropped
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} q_state_e;

  q_state_e                state_q, state_d;
  logic [3:0]              inflight_q, inflight_d;
  logic [3:0]              drop_q, drop_d;
  logic [c_resp_nbits-1:0] entry0_q, entry0_d;
  logic [c_resp_nbits-1:0] entry1_q, entry1_d;

  logic room;
  logic req_fire;
  logic resp_fire;
  logic drop_nz;
  logic discard;
  logic enq;
  logic deq;

  // Request path is purely combinational
  assign room         = inflight_q < 4'(p_max_inflight);
  assign mem_req_val  = proc_req_val & room;
  assign proc_req_rdy = mem_req_rdy & room;
  assign mem_req_msg  = proc_req_msg;
  assign req_fire     = proc_req_val & proc_req_rdy;

  assign drop_nz       = (drop_q != 4'd0);
  assign mem_resp_rdy  = drop_nz | squash | (state_q != StFull);
  assign resp_fire     = mem_resp_val & mem_resp_rdy;
  assign discard       = resp_fire & (drop_nz | squash);
  assign enq           = resp_fire & ~discard;

  assign proc_resp_val = (state_q != StEmpty);
  assign proc_resp_msg = entry0_q;
  assign deq           = proc_resp_val & proc_resp_rdy;

  always_comb begin
    inflight_d = inflight_q;
    if (req_fire && !resp_fire) begin
      inflight_d = inflight_q + 4'd1;
    end else if (!req_fire && resp_fire) begin
      inflight_d = inflight_q - 4'd1;
    end
  end

  // Requests firing in the squash cycle are not yet counted in inflight_q, so they survive
  always_comb begin
    drop_d = drop_q;
    if (squash) begin
      drop_d = inflight_q - 4'(resp_fire);
    end else if (resp_fire && drop_nz) begin
      drop_d = drop_q - 4'd1;
    end
  end

  // Entry 0 is always the head; entry 1 shifts down on a dequeue from FULL
  always_comb begin
    state_d  = state_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    if (squash) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (enq) begin
            state_d  = StOne;
            entry0_d = mem_resp_msg;
          end
        end
        StOne: begin
          if (enq && deq) begin
            entry0_d = mem_resp_msg;
          end else if (enq) begin
            state_d  = StFull;
            entry1_d = mem_resp_msg;
          end else if (deq) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (deq) begin
            state_d  = StOne;
            entry0_d = entry1_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEmpty;
      inflight_q <= 4'd0;
      drop_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    entry0_q <= entry0_d;
    entry1_q <= entry1_d;
  end

`ifdef LAB2_PROC_IMEM_FILTER_STATS_EN
  logic [31:0] num_dropped_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      num_dropped_q <= 32'd0;
    end else if (discard) begin
      num_dropped_q <= num_dropped_q + 32'd1;
    end
  end

  assign num_dropped = num_dropped_q;
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding means the memory side broke protocol
  assert property (@(posedge clk) disable iff (reset)
    !(mem_resp_val && mem_resp_rdy && (inflight_q == 4'd0)))
    else $error("imem_resp_filter: response received with no request in flight");

  function automatic string line_trace();
    string s;
    case (state_q)
      StEmpty: s = "  ";
      StOne:   s = "* ";
      default: s = "**";
    endcase
`ifdef LAB2_PROC_IMEM_FILTER_STATS_EN
    s = discard ? {s, "d"} : {s, " "};
`endif
    return s;
  endfunction
`endif

endmodule

// File: tb/tb_lab2_proc_imem_resp_filter.sv
// Directed bench for lab2_proc_imem_resp_filter: flow, inflight cap, squash, backpressure, reset.
module tb_lab2_proc_imem_resp_filter;

  localparam int unsigned ReqW  = 77;
  localparam int unsigned RespW = 47;

  logic             clk;
  logic             reset;
  logic             squash;
  logic             proc_req_val;
  logic             proc_req_rdy;
  logic [ReqW-1:0]  proc_req_msg;
  logic             mem_req_val;
  logic             mem_req_rdy;
  logic [ReqW-1:0]  mem_req_msg;
  logic             mem_resp_val;
  logic             mem_resp_rdy;
  logic [RespW-1:0] mem_resp_msg;
  logic             proc_resp_val;
  logic             proc_resp_rdy;
  logic [RespW-1:0] proc_resp_msg;
`ifdef LAB2_PROC_IMEM_FILTER_STATS_EN
  logic [31:0]      num_dropped;
`endif

  int total;
  int bad;

  lab2_proc_imem_resp_filter dut (
    .clk           (clk),
    .reset         (reset),
    .squash        (squash),
    .proc_req_val  (proc_req_val),
    .proc_req_rdy  (proc_req_rdy),
    .proc_req_msg  (proc_req_msg),
    .mem_req_val   (mem_req_val),
    .mem_req_rdy   (mem_req_rdy),
    .mem_req_msg   (mem_req_msg),
    .mem_resp_val  (mem_resp_val),
    .mem_resp_rdy  (mem_resp_rdy),
    .mem_resp_msg  (mem_resp_msg),
    .proc_resp_val (proc_resp_val),
    .proc_resp_rdy (proc_resp_rdy),
    .proc_resp_msg (proc_resp_msg)
`ifdef LAB2_PROC_IMEM_FILTER_STATS_EN
    ,
    .num_dropped   (num_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset         = 1'b1;
    squash        = 1'b0;
    proc_req_val  = 1'b0;
    proc_req_msg  = '0;
    mem_req_rdy   = 1'b1;
    mem_resp_val  = 1'b0;
    mem_resp_msg  = '0;
    proc_resp_rdy = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_resp_val", proc_resp_val, 0);
    check("rst_mem_resp_rdy", mem_resp_rdy, 1);
    check("rst_inflight", dut.inflight_q, 0);
    check("rst_drop", dut.drop_q, 0);
    mem_req_rdy = 1'b0;
    #1 check("rst_req_rdy_lo", proc_req_rdy, 0);
    mem_req_rdy = 1'b1;
    #1 check("rst_req_rdy_hi", proc_req_rdy, 1);
`ifdef LAB2_PROC_IMEM_FILTER_STATS_EN
    check("rst_num_dropped", num_dropped, 0);
`endif

    // Basic flow: 3 requests, zero-delay memory, responses one cycle after memory
    for (int i = 0; i < 5; i++) begin
      proc_req_val = (i < 3);
      proc_req_msg = ReqW'(32'hA000 + i);
      mem_resp_val = (i >= 1 && i <= 3);
      mem_resp_msg = RespW'(32'hB000 + i - 1);
      #1;
      check("basic_inflight", dut.inflight_q, (i == 0 || i == 4) ? 0 : 1);
      check("basic_req_val", mem_req_val, (i < 3));
      if (i < 3) check("basic_req_msg", mem_req_msg, ReqW'(32'hA000 + i));
      check("basic_resp_val", proc_resp_val, (i >= 2));
      if (i >= 2) check("basic_resp_msg", proc_resp_msg, RespW'(32'hB000 + i - 2));
      tick();
    end
    proc_req_val = 1'b0;
    mem_resp_val = 1'b0;
    #1;
    check("basic_idle_val", proc_resp_val, 0);
    check("basic_idle_inflight", dut.inflight_q, 0);

    // Inflight limit: memory holds responses, 6 request attempts
    proc_req_val = 1'b1;
    for (int i = 0; i < 6; i++) begin
      proc_req_msg = ReqW'(32'hC000 + i);
      #1;
      check("lim_req_rdy", proc_req_rdy, (i < 4));
      check("lim_mem_req_val", mem_req_val, (i < 4));
      tick();
    end
    check("lim_inflight", dut.inflight_q, 4);
    mem_resp_val = 1'b1;
    mem_resp_msg = RespW'(32'h0D00);
    #1;
    check("lim_req_rdy_full", proc_req_rdy, 0);
    check("lim_resp_rdy", mem_resp_rdy, 1);
    tick();
    proc_req_val = 1'b0;
    mem_resp_val = 1'b0;
    #1;
    check("lim_req_rdy_back", proc_req_rdy, 1);
    check("lim_resp_val", proc_resp_val, 1);
    check("lim_resp_msg", proc_resp_msg, RespW'(32'h0D00));
    check("lim_inflight3", dut.inflight_q, 3);
    tick();

    // Squash with 3 outstanding plus a new request in the squash cycle
    squash       = 1'b1;
    proc_req_val = 1'b1;
    proc_req_msg = ReqW'(32'hE000);
    #1;
    check("sq_new_req_val", mem_req_val, 1);
    tick();
    squash       = 1'b0;
    proc_req_val = 1'b0;
    #1;
    check("sq_drop3", dut.drop_q, 3);
    check("sq_inflight4", dut.inflight_q, 4);
    check("sq_resp_val", proc_resp_val, 0);
    for (int k = 0; k < 3; k++) begin
      mem_resp_val = 1'b1;
      mem_resp_msg = RespW'(32'h0F00 + k);
      #1;
      check("sq_old_rdy", mem_resp_rdy, 1);
      check("sq_drop_cnt", dut.drop_q, 3 - k);
      check("sq_no_leak", proc_resp_val, 0);
      tick();
    end
    mem_resp_msg = RespW'(32'h0E0E);
    #1;
    check("sq_last_no_leak", proc_resp_val, 0);
    check("sq_drop0", dut.drop_q, 0);
    check("sq_inflight1", dut.inflight_q, 1);
    tick();
    mem_resp_val = 1'b0;
    #1;
    check("sq_new_val", proc_resp_val, 1);
    check("sq_new_msg", proc_resp_msg, RespW'(32'h0E0E));
    check("sq_inflight0", dut.inflight_q, 0);
`ifdef LAB2_PROC_IMEM_FILTER_STATS_EN
    check("sq_num_dropped", num_dropped, 3);
`endif
    tick();

    // Squash coinciding with a response fire, inflight = 2
    proc_req_val = 1'b1;
    tick();
    tick();
    proc_req_val = 1'b0;
    #1;
    check("sqr_inflight2", dut.inflight_q, 2);
    squash       = 1'b1;
    mem_resp_val = 1'b1;
    mem_resp_msg = RespW'(32'h1111);
    #1;
    check("sqr_resp_rdy", mem_resp_rdy, 1);
    tick();
    squash       = 1'b0;
    mem_resp_msg = RespW'(32'h2222);
    #1;
    check("sqr_drop1", dut.drop_q, 1);
    check("sqr_inflight1", dut.inflight_q, 1);
    check("sqr_val0", proc_resp_val, 0);
    check("sqr_resp_rdy2", mem_resp_rdy, 1);
    tick();
    mem_resp_val = 1'b0;
    #1;
    check("sqr_drop0", dut.drop_q, 0);
    check("sqr_inflight0", dut.inflight_q, 0);
    check("sqr_val_after", proc_resp_val, 0);
`ifdef LAB2_PROC_IMEM_FILTER_STATS_EN
    check("sqr_num_dropped", num_dropped, 5);
`endif

    // Backpressure: two queued responses block memory, then drain
    proc_resp_rdy = 1'b0;
    proc_req_val  = 1'b1;
    tick();
    tick();
    tick();
    proc_req_val = 1'b0;
    mem_resp_val = 1'b1;
    mem_resp_msg = RespW'(32'h0A0A);
    tick();
    mem_resp_msg = RespW'(32'h0B0B);
    #1;
    check("bp_rdy_one", mem_resp_rdy, 1);
    tick();
    mem_resp_msg = RespW'(32'h0C0C);
    #1;
    check("bp_rdy_full", mem_resp_rdy, 0);
    check("bp_val", proc_resp_val, 1);
    check("bp_head_a", proc_resp_msg, RespW'(32'h0A0A));
    check("bp_inflight1", dut.inflight_q, 1);
    tick();
    check("bp_hold_a", proc_resp_msg, RespW'(32'h0A0A));
    check("bp_hold_rdy", mem_resp_rdy, 0);
    check("bp_hold_inflight", dut.inflight_q, 1);
    proc_resp_rdy = 1'b1;
    tick();
    check("bp_head_b", proc_resp_msg, RespW'(32'h0B0B));
    check("bp_rdy_open", mem_resp_rdy, 1);
    tick();
    mem_resp_val = 1'b0;
    #1;
    check("bp_val_c", proc_resp_val, 1);
    check("bp_head_c", proc_resp_msg, RespW'(32'h0C0C));
    check("bp_inflight0", dut.inflight_q, 0);
    tick();
    check("bp_empty", proc_resp_val, 0);

    // Reset mid-stream with queue FULL and inflight = 3
    proc_resp_rdy = 1'b0;
    proc_req_val  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    proc_req_val = 1'b0;
    mem_resp_val = 1'b1;
    mem_resp_msg = RespW'(32'h3333);
    tick();
    proc_req_val = 1'b1;
    mem_resp_msg = RespW'(32'h4444);
    #1;
    check("mr_req_rdy", proc_req_rdy, 1);
    tick();
    proc_req_val = 1'b0;
    mem_resp_val = 1'b0;
    #1;
    check("mr_full_rdy", mem_resp_rdy, 0);
    check("mr_full_val", proc_resp_val, 1);
    check("mr_inflight3", dut.inflight_q, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mr_val0", proc_resp_val, 0);
    check("mr_inflight0", dut.inflight_q, 0);
    check("mr_drop0", dut.drop_q, 0);
    check("mr_resp_rdy", mem_resp_rdy, 1);
`ifdef LAB2_PROC_IMEM_FILTER_STATS_EN
    check("mr_num_dropped", num_dropped, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lab2_proc_imem_resp_filter.md
# lab2_proc_imem_resp_filter

Sits between the processor fetch stage and port 0 of the dual-ported random-delay test memory. It forwards fetch requests and limits how many are outstanding. On a squash (redirect), it drops the responses to every request issued before the squash, and it buffers surviving responses in a 2-entry queue so the fetch stage sees registered, in-order responses.

## Interface
- p_max_inflight, 4: maximum outstanding requests (requests fired to memory whose responses have not yet returned from memory); must be 1..15.
- p_opaque_nbits, 8: opaque field width of the mem message.
- c_req_nbits, $bits(mem_req_4B_t): request message width.
- c_resp_nbits, $bits(mem_resp_4B_t): response message width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- squash  in  1  one-cycle pulse: responses to all previously issued requests must be dropped.
- proc_req_val  in  1  fetch request valid.
- proc_req_rdy  out  1  fetch request ready.
- proc_req_msg  in  c_req_nbits  request, passed unmodified.
- mem_req_val  out  1  to memory port 0.
- mem_req_rdy  in  1  from memory port 0.
- mem_req_msg  out  c_req_nbits  equal to proc_req_msg.
- mem_resp_val  in  1  from memory port 0.
- mem_resp_rdy  out  1  to memory port 0.
- mem_resp_msg  in  c_resp_nbits  response from memory.
- proc_resp_val  out  1  surviving response valid.
- proc_resp_rdy  in  1  fetch stage ready.
- proc_resp_msg  out  c_resp_nbits  head of the response queue.

## Operation
- Request path:
  - mem_req_val = proc_req_val & room.
  - proc_req_rdy = mem_req_rdy & room.
  - mem_req_msg = proc_req_msg.
  - room = (inflight < p_max_inflight).
  - Combinational path; no buffering.
- inflight counter (4 bits):
  - +1 on a request fire (val & rdy).
  - −1 on a response fire from memory.
  - Both in the same cycle: unchanged.
- drop counter (4 bits): number of in-flight responses still to be discarded.
  - On squash: drop_next = inflight − (1 if a response fires this cycle, else 0).
  - Without squash: decrements by 1 on each response fire from memory while drop > 0.
- Squash timing rules:
  - A request firing in the squash cycle is NOT dropped.
  - A response firing in the squash cycle IS dropped.
- Response accept/discard:
  - mem_resp_rdy = (drop > 0) | (squash) | (queue not full).
  - A response is discarded (never enqueued) when drop > 0 or squash is high.
  - Otherwise it is enqueued.
- Response queue: 2-entry normal FIFO, states EMPTY / ONE / FULL.
  - Enqueue while FULL is impossible by construction.
  - Simultaneous enqueue and dequeue in ONE stays ONE.
  - Simultaneous enqueue and dequeue in FULL is not allowed: memory is not ready while FULL, so no enqueue occurs.
  - squash also flushes the queue to EMPTY in the same edge; the flush takes precedence over dequeue.
- proc_resp_val = queue not EMPTY.
- proc_resp_msg = head entry. Before the first write the head contents are undefined; proc_resp_val is 0 in that case.

## Timing
- Reset values:
  - inflight = 0, drop = 0, queue EMPTY.
  - proc_resp_val = 0, mem_resp_rdy = 1, proc_req_rdy = mem_req_rdy.
- Request latency: 0 cycles (combinational pass-through).
- Response latency: a response accepted at edge N is visible on proc_resp_val in cycle N+1.
- Maximum throughput: 1 response per cycle when proc_resp_rdy is held high.
- Squash behaviour:
  - Squash at edge N: proc_resp_val is 0 in cycle N+1, unless a new response is accepted then (not possible, because drop covers all in-flight responses).
  - Back-to-back squashes recompute drop from inflight each time; there is no accumulation.
- inflight saturation:
  - Never exceeds p_max_inflight.
  - Never underflows: a response arriving with inflight = 0 is a protocol error and triggers an assertion in simulation.
- Reset mid-operation: all counters and the queue are cleared the next edge. Stale memory responses after reset are not the block's concern; the memory is reset on the same signal.

## Configuration
- LAB2_PROC_IMEM_FILTER_STATS_EN
  - Defined: adds output port num_dropped (out, 32 bits), which counts discarded responses. It resets to 0 and wraps at 2^32. The line trace also appends "d" on each cycle that has a drop.
  - Undefined: the port and the counter are absent, and the line trace shows only queue occupancy.

## Test plan
- Basic flow: after reset, issue 3 requests with zero-delay memory and proc_resp_rdy = 1 → 3 responses, each appearing 1 cycle after its memory response, in order, with inflight returning to 0.
- Inflight limit: memory holds all responses, proc issues 6 requests → only 4 (p_max_inflight) fire and proc_req_rdy stays 0 until the first response returns.
- Squash with 3 outstanding: pulse squash, and issue a new request in the same cycle → the 3 old responses are discarded, and the new request's response is delivered; num_dropped = 3.
- Squash coinciding with a response fire: inflight = 2 and one response fires in the squash cycle → drop = 1, and both old responses are discarded.
- Backpressure: proc_resp_rdy = 0 with 2 responses queued → mem_resp_rdy = 0. Raise rdy → entries drain on consecutive cycles, and the third response is then accepted.
- Reset mid-stream: assert reset with queue FULL and inflight = 3 → the next cycle has proc_resp_val = 0, inflight = 0, drop = 0.
